sdram_rom_arbiter: RTL and testbench

Shares the single SDRAM read/write port among the four ROM clients of the arcade core: download writer, main CPU, sound CPU and sprite fetch. The block sits between those clients and the SDRAM command controller, and runs on the memory clock. It turns address changes into read requests and merges sprite data into 32-bit words. While a download is active, it gives the port exclusively to download writes.

---
 rtl/rom_arb_pkg.sv | 18 +
 rtl/rom_arb_chan.sv | 34 +++
 rtl/sdram_rom_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_sdram_rom_arbiter.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_arb_pkg.sv
// Shared types for the SDRAM ROM arbiter: channel ids, FSM states and the
// round-robin successor function.
package rom_arb_pkg;

    localparam int AW_DEFAULT = 23;

    typedef enum logic [1:0] {CH_CPU, CH_SND, CH_SPR} chan_t;
    typedef enum logic [1:0] {IDLE, ISSUE, SPR_HI} arb_state_t;

    function automatic chan_t next_chan(input chan_t c);
        case (c)
            CH_CPU:  return CH_SND;
            CH_SND:  return CH_SPR;
            default: return CH_CPU;
        endcase
    endfunction

endpackage

// File: rtl/rom_arb_chan.sv
// One read client: remembers the address last granted and reports whether the
// client needs service or already holds valid data.
module rom_arb_chan #(
    parameter int W = 23
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] addr,
    input  logic         grant,
    input  logic         done,
    output logic         pending,
    output logic         rdy
);

    logic [W-1:0] last_addr;
    logic         in_service;

    // All-ones reset forces a fetch of whatever address the client presents first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_addr  <= '1;
            in_service <= 1'b0;
        end else if (grant) begin
            last_addr  <= addr;
            in_service <= 1'b1;
        end else if (done) begin
            in_service <= 1'b0;
        end
    end

    assign pending = (addr != last_addr) || in_service;
    assign rdy     = (addr == last_addr) && !in_service;

endmodule

// File: rtl/sdram_rom_arbiter.sv
// Shares one SDRAM port between the download writer and the cpu, sound and
// sprite ROM readers; sprite reads are two 16-bit beats merged into 32 bits.
module sdram_rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int AW = AW_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          dl_active,
    input  logic          dl_wr,
    input  logic [AW-1:0] dl_addr,
    input  logic [15:0]   dl_data,
    input  logic [1:0]    dl_ds,
    output logic          dl_busy,
    output logic          dl_overrun,
    input  logic [AW-1:0] cpu_addr,
    output logic [15:0]   cpu_q,
    output logic          cpu_rdy,
    input  logic [AW-1:0] snd_addr,
    output logic [15:0]   snd_q,
    output logic          snd_rdy,
    input  logic [AW-2:0] spr_addr,
    output logic [31:0]   spr_q,
    output logic          spr_rdy,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [15:0]   mem_d,
    output logic [1:0]    mem_ds,
    input  logic          mem_ack,
    input  logic [15:0]   mem_q
);

    arb_state_t    state, state_nx;
    chan_t         rr_ptr, cur_ch, sel_ch, cand;
    logic          sel_valid, start_wr, start_rd, ack_lo, fin;
    logic [2:0]    pend, grant, done;
    logic [AW-1:0] dl_addr_r;
    logic [15:0]   dl_data_r;
    logic [1:0]    dl_ds_r;

    rom_arb_chan #(.W(AW)) u_cpu (
        .clk(clk), .reset(reset), .addr(cpu_addr), .grant(grant[CH_CPU]),
        .done(done[CH_CPU]), .pending(pend[CH_CPU]), .rdy(cpu_rdy)
    );
    rom_arb_chan #(.W(AW)) u_snd (
        .clk(clk), .reset(reset), .addr(snd_addr), .grant(grant[CH_SND]),
        .done(done[CH_SND]), .pending(pend[CH_SND]), .rdy(snd_rdy)
    );
    rom_arb_chan #(.W(AW-1)) u_spr (
        .clk(clk), .reset(reset), .addr(spr_addr), .grant(grant[CH_SPR]),
        .done(done[CH_SPR]), .pending(pend[CH_SPR]), .rdy(spr_rdy)
    );

    // Round-robin search starting at the pointer.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        sel_valid = 1'b0;
        sel_ch    = CH_CPU;
        cand      = rr_ptr;
        for (int i = 0; i < 3; i++) begin
            if (!sel_valid && pend[cand]) begin
                sel_valid = 1'b1;
                sel_ch    = cand;
            end
            cand = next_chan(cand);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        start_wr = 1'b0;
        start_rd = 1'b0;
        ack_lo   = 1'b0;
        fin      = 1'b0;
        case (state)
            IDLE: begin
                if (dl_busy) begin
                    start_wr = 1'b1;
                    state_nx = ISSUE;
                end else if (!dl_active && sel_valid) begin
                    start_rd = 1'b1;
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_ack) begin
                    if (!mem_we && cur_ch == CH_SPR) begin
                        ack_lo   = 1'b1;
                        state_nx = SPR_HI;
                    end else begin
                        fin      = 1'b1;
                        state_nx = IDLE;
                    end
                end
            end
            SPR_HI: begin
                if (mem_ack) begin
                    fin      = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        grant = '0;
        done  = '0;
        if (start_rd)        grant[sel_ch] = 1'b1;
        if (fin && !mem_we)  done[cur_ch]  = 1'b1;
    end

    // Command fields are registered and held for the whole request.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_d    <= '0;
            mem_ds   <= '0;
            cur_ch   <= CH_CPU;
            rr_ptr   <= CH_CPU;
        end else if (start_wr) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b1;
            mem_addr <= dl_addr_r;
            mem_d    <= dl_data_r;
            mem_ds   <= dl_ds_r;
        end else if (start_rd) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_d    <= '0;
            mem_ds   <= 2'b11;
            cur_ch   <= sel_ch;
            rr_ptr   <= next_chan(sel_ch);
            case (sel_ch)
                CH_CPU:  mem_addr <= cpu_addr;
                CH_SND:  mem_addr <= snd_addr;
                default: mem_addr <= {spr_addr, 1'b0};
            endcase
        end else if (ack_lo) begin
            mem_addr[0] <= 1'b1;
        end else if (fin) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
        end
    end

    // A new strobe is only accepted once the previous write has been acked.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dl_busy    <= 1'b0;
            dl_overrun <= 1'b0;
            dl_addr_r  <= '0;
            dl_data_r  <= '0;
            dl_ds_r    <= '0;
        end else begin
            if (fin && mem_we) dl_busy <= 1'b0;
            if (dl_wr) begin
                if (dl_busy) begin
                    dl_overrun <= 1'b1;
                end else begin
                    dl_busy   <= 1'b1;
                    dl_addr_r <= dl_addr;
                    dl_data_r <= dl_data;
                    dl_ds_r   <= dl_ds;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_q <= '0;
            snd_q <= '0;
            spr_q <= '0;
        end else if (mem_ack && !mem_we && state == ISSUE) begin
            case (cur_ch)
                CH_CPU:  cpu_q        <= mem_q;
                CH_SND:  snd_q        <= mem_q;
                default: spr_q[15:0]  <= mem_q;
            endcase
        end else if (mem_ack && state == SPR_HI) begin
            spr_q[31:16] <= mem_q;
        end
    end

endmodule

// File: tb/tb_sdram_rom_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a transaction-level model.
module tb_sdram_rom_arbiter;
    import rom_arb_pkg::*;

    localparam int AW = 23;

    logic          clk = 1'b0;
    logic          reset;
    logic          dl_active, dl_wr;
    logic [AW-1:0] dl_addr;
    logic [15:0]   dl_data;
    logic [1:0]    dl_ds;
    logic          dl_busy, dl_overrun;
    logic [AW-1:0] cpu_addr, snd_addr;
    logic [AW-2:0] spr_addr;
    logic [15:0]   cpu_q, snd_q;
    logic [31:0]   spr_q;
    logic          cpu_rdy, snd_rdy, spr_rdy;
    logic          mem_req, mem_we, mem_ack;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_d, mem_q;
    logic [1:0]    mem_ds;

    sdram_rom_arbiter #(.AW(AW)) dut (
        .clk(clk), .reset(reset), .dl_active(dl_active), .dl_wr(dl_wr),
        .dl_addr(dl_addr), .dl_data(dl_data), .dl_ds(dl_ds), .dl_busy(dl_busy),
        .dl_overrun(dl_overrun), .cpu_addr(cpu_addr), .cpu_q(cpu_q), .cpu_rdy(cpu_rdy),
        .snd_addr(snd_addr), .snd_q(snd_q), .snd_rdy(snd_rdy), .spr_addr(spr_addr),
        .spr_q(spr_q), .spr_rdy(spr_rdy), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_d(mem_d), .mem_ds(mem_ds), .mem_ack(mem_ack),
        .mem_q(mem_q)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory responder: acks after lat request cycles, data from ack_q or random.
    int          lat = 3;
    bit          stray_en = 1'b0;
    logic [15:0] ack_q[$];
    int          rcnt = 0;

    initial begin
        mem_ack = 1'b0;
        mem_q   = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            if (reset) begin
                rcnt = 0;
            end else if (mem_req) begin
                rcnt++;
                if (rcnt >= lat) begin
                    rcnt    = 0;
                    mem_ack = 1'b1;
                    if (ack_q.size() != 0) mem_q = ack_q.pop_front();
                    else                   mem_q = 16'($urandom);
                end
            end else begin
                rcnt = 0;
                if (stray_en && $urandom_range(0, 15) == 0) begin
                    mem_ack = 1'b1;
                    mem_q   = 16'($urandom);
                end
            end
        end
    end

    // Transaction-level model: a queue of expected memory beats plus per-client state.
    typedef struct {
        bit            we;
        logic [AW-1:0] addr;
        logic [15:0]   d;
        logic [1:0]    ds;
        int            ch;
        bit            hi;
    } beat_t;

    beat_t         beats[$];
    logic [AW-1:0] m_last[3];
    int            m_ptr;
    bit            m_dl_busy, m_ovr;
    logic [AW-1:0] m_dl_addr;
    logic [15:0]   m_dl_data, m_cpu_q, m_snd_q;
    logic [1:0]    m_dl_ds;
    logic [31:0]   m_spr_q;

    function automatic logic [AW-1:0] ch_addr(input int c);
        if (c == 0) return cpu_addr;
        if (c == 1) return snd_addr;
        return {1'b0, spr_addr};
    endfunction

    function automatic bit in_svc(input int c);
        return (beats.size() != 0) && (beats[0].ch == c);
    endfunction

    always @(posedge clk or posedge reset) begin
        bit    busy0, found;
        beat_t b;
        int    c;
        if (reset) begin
            beats.delete();
            m_last[0] = '1;
            m_last[1] = '1;
            m_last[2] = {1'b0, {(AW-1){1'b1}}};
            m_ptr = 0;
            m_dl_busy = 1'b0;
            m_ovr = 1'b0;
            m_cpu_q = '0;
            m_snd_q = '0;
            m_spr_q = '0;
        end else begin
            busy0 = m_dl_busy;
            found = 1'b0;
            if (beats.size() != 0) begin
                if (mem_ack) begin
                    b = beats.pop_front();
                    case (b.ch)
                        3: m_dl_busy = 1'b0;
                        0: m_cpu_q = mem_q;
                        1: m_snd_q = mem_q;
                        default: if (b.hi) m_spr_q[31:16] = mem_q; else m_spr_q[15:0] = mem_q;
                    endcase
                end
            end else if (busy0) begin
                beats.push_back('{we: 1'b1, addr: m_dl_addr, d: m_dl_data, ds: m_dl_ds, ch: 3, hi: 1'b0});
            end else if (!dl_active) begin
                for (int k = 0; k < 3; k++) begin
                    c = (m_ptr + k) % 3;
                    if (!found && ch_addr(c) != m_last[c]) begin
                        found = 1'b1;
                        m_last[c] = ch_addr(c);
                        if (c == 2) begin
                            beats.push_back('{we: 1'b0, addr: {spr_addr, 1'b0}, d: 16'h0, ds: 2'b11, ch: 2, hi: 1'b0});
                            beats.push_back('{we: 1'b0, addr: {spr_addr, 1'b1}, d: 16'h0, ds: 2'b11, ch: 2, hi: 1'b1});
                        end else begin
                            beats.push_back('{we: 1'b0, addr: ch_addr(c), d: 16'h0, ds: 2'b11, ch: c, hi: 1'b0});
                        end
                        m_ptr = (c + 1) % 3;
                    end
                end
            end
            if (dl_wr) begin
                if (busy0) begin
                    m_ovr = 1'b1;
                end else begin
                    m_dl_busy = 1'b1;
                    m_dl_addr = dl_addr;
                    m_dl_data = dl_data;
                    m_dl_ds   = dl_ds;
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        bit req_e;
        if (!reset) begin
            req_e = (beats.size() != 0);
            check("mem_req", 32'(mem_req), 32'(req_e));
            if (req_e) begin
                check("mem_we", 32'(mem_we), 32'(beats[0].we));
                check("mem_addr", 32'(mem_addr), 32'(beats[0].addr));
                check("mem_ds", 32'(mem_ds), 32'(beats[0].ds));
                if (beats[0].we) check("mem_d", 32'(mem_d), 32'(beats[0].d));
            end
            check("cpu_q", 32'(cpu_q), 32'(m_cpu_q));
            check("snd_q", 32'(snd_q), 32'(m_snd_q));
            check("spr_q", spr_q, m_spr_q);
            check("dl_busy", 32'(dl_busy), 32'(m_dl_busy));
            check("dl_overrun", 32'(dl_overrun), 32'(m_ovr));
            check("cpu_rdy", 32'(cpu_rdy), 32'((cpu_addr == m_last[0]) && !in_svc(0)));
            check("snd_rdy", 32'(snd_rdy), 32'((snd_addr == m_last[1]) && !in_svc(1)));
            check("spr_rdy", 32'(spr_rdy), 32'(({1'b0, spr_addr} == m_last[2]) && !in_svc(2)));
        end
    end

    // Request-start log used by the directed ordering checks.
    bit            req_prev = 1'b0;
    int            req_rises = 0;
    logic [AW-1:0] req_log[$];

    always @(negedge clk) begin
        if (mem_req && !req_prev) begin
            req_rises++;
            req_log.push_back(mem_addr);
        end
        req_prev = mem_req;
    end

    function automatic logic [31:0] log_at(input int i);
        if (i < req_log.size()) return 32'(req_log[i]);
        return 32'hFFFF_FFFF;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_quiet(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!(!mem_req && cpu_rdy && snd_rdy && spr_rdy && !dl_busy) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({name, "_quiet_timeout"}, 32'(n < 400), 32'd1);
    endtask

    task automatic wait_req_addr(input string name, input logic [AW-1:0] a, input bit any);
        int n;
        n = 0;
        @(negedge clk);
        while (!(mem_req && (any || mem_addr == a)) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({name, "_req_timeout"}, 32'(n < 100), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, base;
        reset = 1'b1;
        dl_active = 1'b1;
        dl_wr = 1'b0;
        dl_addr = '0;
        dl_data = '0;
        dl_ds = '0;
        cpu_addr = '0;
        snd_addr = '0;
        spr_addr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_d", 32'(mem_d), 32'd0);
        check("rst_mem_ds", 32'(mem_ds), 32'd0);
        check("rst_q", {cpu_q, snd_q} | spr_q, 32'd0);
        check("rst_dl", {30'd0, dl_busy, dl_overrun}, 32'd0);
        check("rst_cpu_rdy", 32'(cpu_rdy), 32'd0);
        tick();
        reset = 1'b0;

        // Download write, then a second strobe while busy.
        lat = 3;
        tick();
        base = req_rises;
        dl_wr = 1'b1; dl_addr = 23'h10; dl_data = 16'hA5A5; dl_ds = 2'b01;
        tick();
        dl_wr = 1'b1; dl_addr = 23'h20; dl_data = 16'h1111; dl_ds = 2'b11;
        tick();
        dl_wr = 1'b0;
        @(negedge clk);
        check("dl_mem_req", 32'(mem_req), 32'd1);
        check("dl_mem_we", 32'(mem_we), 32'd1);
        check("dl_mem_addr", 32'(mem_addr), 32'h10);
        check("dl_mem_d", 32'(mem_d), 32'hA5A5);
        check("dl_mem_ds", 32'(mem_ds), 32'h1);
        check("dl_overrun_set", 32'(dl_overrun), 32'd1);
        n = 0;
        while (dl_busy && n < 20) begin @(negedge clk); n++; end
        check("dl_busy_clear_timeout", 32'(n < 20), 32'd1);
        repeat (10) @(negedge clk);
        check("dl_single_req", 32'(req_rises - base), 32'd1);
        check("dl_gates_reads", 32'(mem_req), 32'd0);
        check("dl_overrun_sticky", 32'(dl_overrun), 32'd1);

        // First cpu read after download ends: address 0 against all-ones history.
        ack_q.push_back(16'h1234);
        tick();
        dl_active = 1'b0;
        wait_req_addr("cpu0", '0, 1'b1);
        check("cpu0_addr", 32'(mem_addr), 32'd0);
        check("cpu0_we", 32'(mem_we), 32'd0);
        check("cpu0_ds", 32'(mem_ds), 32'd3);
        wait_quiet("cpu0");
        check("cpu0_q", 32'(cpu_q), 32'h1234);
        check("cpu0_rdy", 32'(cpu_rdy), 32'd1);
        base = req_rises;
        repeat (20) @(negedge clk);
        check("hold_no_req", 32'(req_rises - base), 32'd0);

        // Sprite read: two beats merged.
        ack_q.push_back(16'hBEEF);
        ack_q.push_back(16'hCAFE);
        tick();
        spr_addr = 22'h40;
        wait_req_addr("spr_lo", '0, 1'b1);
        check("spr_lo_addr", 32'(mem_addr), 32'h80);
        wait_req_addr("spr_hi", 23'h81, 1'b0);
        check("spr_rdy_between", 32'(spr_rdy), 32'd0);
        check("spr_lo_loaded", {16'h0, spr_q[15:0]}, 32'hBEEF);
        wait_quiet("spr");
        check("spr_q", spr_q, 32'hCAFEBEEF);
        check("spr_rdy", 32'(spr_rdy), 32'd1);

        // Round robin from cpu, then from snd.
        req_log.delete();
        tick();
        cpu_addr = 23'h111; snd_addr = 23'h222; spr_addr = 22'h333;
        wait_quiet("rr1");
        check("rr1_n", 32'(req_log.size()), 32'd3);
        check("rr1_0", log_at(0), 32'h111);
        check("rr1_1", log_at(1), 32'h222);
        check("rr1_2", log_at(2), 32'h666);
        tick();
        cpu_addr = 23'h123;
        wait_quiet("rr_mid");
        req_log.delete();
        tick();
        cpu_addr = 23'h456; snd_addr = 23'h789; spr_addr = 22'h0AB;
        wait_quiet("rr2");
        check("rr2_n", 32'(req_log.size()), 32'd3);
        check("rr2_0", log_at(0), 32'h789);
        check("rr2_1", log_at(1), 32'h156);
        check("rr2_2", log_at(2), 32'h456);

        // Address change while in service.
        lat = 4;
        ack_q.push_back(16'h5555);
        ack_q.push_back(16'h6666);
        tick();
        cpu_addr = 23'h100;
        wait_req_addr("chg1", 23'h100, 1'b0);
        tick();
        cpu_addr = 23'h200;
        n = 0;
        @(negedge clk);
        while (mem_req && n < 50) begin @(negedge clk); n++; end
        check("chg_ack_timeout", 32'(n < 50), 32'd1);
        check("chg_old_q", 32'(cpu_q), 32'h5555);
        check("chg_old_rdy", 32'(cpu_rdy), 32'd0);
        wait_req_addr("chg2", '0, 1'b1);
        check("chg2_addr", 32'(mem_addr), 32'h200);
        wait_quiet("chg");
        check("chg_new_q", 32'(cpu_q), 32'h6666);

        // Asynchronous reset in the middle of the sprite high beat.
        ack_q.push_back(16'hAA11);
        ack_q.push_back(16'hBB22);
        tick();
        spr_addr = 22'h55;
        wait_req_addr("rst_hi", 23'hAB, 1'b0);
        #1 reset = 1'b1;
        #1;
        check("arst_mem_req", 32'(mem_req), 32'd0);
        check("arst_mem_addr", 32'(mem_addr), 32'd0);
        check("arst_mem_ds", 32'(mem_ds), 32'd0);
        check("arst_spr_q", spr_q, 32'd0);
        check("arst_cpu_q", 32'(cpu_q), 32'd0);
        check("arst_overrun", 32'(dl_overrun), 32'd0);
        check("arst_spr_rdy", 32'(spr_rdy), 32'd0);
        ack_q.delete();
        tick();
        reset = 1'b0;
        wait_req_addr("resume", '0, 1'b1);
        check("resume_addr", 32'(mem_addr), 32'h200);
        wait_quiet("resume");

        // Randomized traffic checked by the model every cycle.
        stray_en = 1'b1;
        base = req_rises;
        for (int i = 0; i < 800; i++) begin
            tick();
            dl_wr = 1'b0;
            lat = $urandom_range(1, 3);
            if ($urandom_range(0, 24) == 0) dl_active = ~dl_active;
            if ($urandom_range(0, 9) == 0) cpu_addr = 23'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) snd_addr = 23'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) spr_addr = 22'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) begin
                dl_wr   = 1'b1;
                dl_addr = 23'($urandom);
                dl_data = 16'($urandom);
                dl_ds   = 2'($urandom_range(1, 3));
            end
        end
        tick();
        dl_wr = 1'b0;
        dl_active = 1'b0;
        stray_en = 1'b0;
        wait_quiet("random");
        check("random_activity", 32'(req_rises - base > 20), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
